// File: rtl/timer_counter_core_if.sv
// Control/status bundle between the timer register file and the count engine.
// The register file side uses the master modport. The count engine uses the slave modport.
interface timer_counter_core_if #(
    parameter int WIDTH = 8,
    parameter int PSC_W = 4
);
    logic             load;
    logic             en;
    logic             updown;
    logic             tick;
    logic             auto_reload;
    logic [PSC_W-1:0] psc_div;
    logic [WIDTH-1:0] tdr;
    logic [WIDTH-1:0] cmp;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] last_cnt;
    logic             ovf;
    logic             udf;
    logic             cmp_match;

    modport master (
        output load, en, updown, tick, auto_reload, psc_div, tdr, cmp,
        input  cnt, last_cnt, ovf, udf, cmp_match
    );

    modport slave (
        input  load, en, updown, tick, auto_reload, psc_div, tdr, cmp,
        output cnt, last_cnt, ovf, udf, cmp_match
    );
endinterface

// File: rtl/timer_counter_core.sv
// Parametrised timer count engine with a prescaler and wrap or auto-reload at the limits.
// It produces registered overflow, underflow and compare-match pulses.
module timer_counter_core #(
    parameter int WIDTH = 8,
    parameter int PSC_W = 4
) (
    input logic                 pclk,
    input logic                 preset_n,
    timer_counter_core_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] last_q;
    logic [PSC_W-1:0] psc_q;
    logic             ovf_q;
    logic             udf_q;
    logic             cmp_q;

    logic [WIDTH-1:0] step_val;
    logic             at_limit;
    logic             psc_hit;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        at_limit = bus.updown ? (cnt_q == '0) : (cnt_q == MAX);
        step_val = bus.updown ? cnt_q - WIDTH'(1) : cnt_q + WIDTH'(1);
        if (at_limit) begin
            step_val = bus.auto_reload ? bus.tdr : (bus.updown ? MAX : '0);
        end
        psc_hit = (psc_q == bus.psc_div);
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cnt_q  <= '0;
            last_q <= '0;
            psc_q  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            cmp_q  <= 1'b0;
        end else begin
            last_q <= cnt_q;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            cmp_q  <= 1'b0;
            if (bus.load) begin
                cnt_q <= bus.tdr;
                psc_q <= '0;
            end else if (!bus.en) begin
                psc_q <= '0;
            end else if (bus.tick) begin
                if (psc_hit) begin
                    psc_q <= '0;
                    cnt_q <= step_val;
                    ovf_q <= at_limit & ~bus.updown;
                    udf_q <= at_limit & bus.updown;
                    cmp_q <= (step_val == bus.cmp);
                end else begin
                    // The prescaler wraps modulo 2^PSC_W when psc_div was lowered below psc_cnt.
                    psc_q <= psc_q + PSC_W'(1);
                end
            end
        end
    end

    assign bus.cnt       = cnt_q;
    assign bus.last_cnt  = last_q;
    assign bus.ovf       = ovf_q;
    assign bus.udf       = udf_q;
    assign bus.cmp_match = cmp_q;
endmodule

// File: tb/tb_timer_counter_core.sv
// Self-checking bench for timer_counter_core using a directed vector table, hand-written corner sequences,
// and a randomized run checked against an arithmetic reference model.
module tb_timer_counter_core;
    localparam int WIDTH = 8;
    localparam int PSC_W = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic pclk;
    logic preset_n;

    timer_counter_core_if #(.WIDTH(WIDTH), .PSC_W(PSC_W)) bus ();

    timer_counter_core #(.WIDTH(WIDTH), .PSC_W(PSC_W)) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .bus      (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_cnt, m_last, m_psc;
    bit m_ovf, m_udf, m_cmp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_last = 0; m_psc = 0;
        m_ovf = 0; m_udf = 0; m_cmp = 0;
    endtask

    task automatic model_clock();
        int raw;
        m_last = m_cnt;
        m_ovf = 0; m_udf = 0; m_cmp = 0;
        if (bus.load) begin
            m_cnt = int'(bus.tdr);
            m_psc = 0;
        end else if (!bus.en) begin
            m_psc = 0;
        end else if (bus.tick) begin
            if (m_psc == int'(bus.psc_div)) begin
                m_psc = 0;
                raw = m_cnt + (bus.updown ? -1 : 1);
                if (raw > MAXV) begin
                    m_ovf = 1;
                    m_cnt = bus.auto_reload ? int'(bus.tdr) : 0;
                end else if (raw < 0) begin
                    m_udf = 1;
                    m_cnt = bus.auto_reload ? int'(bus.tdr) : MAXV;
                end else begin
                    m_cnt = raw;
                end
                m_cmp = (m_cnt == int'(bus.cmp));
            end else begin
                m_psc = (m_psc + 1) % (1 << PSC_W);
            end
        end
    endtask

    // One clock: the model follows the edge, and outputs are settled 1 time unit later.
    task automatic cycle();
        @(posedge pclk);
        if (preset_n) model_clock();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".cnt"},       32'(bus.cnt),       32'(m_cnt));
        check({tag, ".last_cnt"},  32'(bus.last_cnt),  32'(m_last));
        check({tag, ".ovf"},       32'(bus.ovf),       32'(m_ovf));
        check({tag, ".udf"},       32'(bus.udf),       32'(m_udf));
        check({tag, ".cmp_match"}, 32'(bus.cmp_match), 32'(m_cmp));
    endtask

    task automatic set_in(input logic ld, input logic e, input logic ud, input logic tk,
                          input logic ar, input logic [7:0] t, input logic [7:0] c);
        bus.load = ld; bus.en = e; bus.updown = ud; bus.tick = tk;
        bus.auto_reload = ar; bus.tdr = t; bus.cmp = c;
    endtask

    typedef struct {
        logic       load, en, updown, tick, ar;
        logic [7:0] tdr, cmp;
        logic [7:0] e_cnt;
        logic       e_ovf, e_udf, e_cmp;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [7:0] prev;
        logic [7:0] exp_v;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFD, 8'h10, 8'hFD, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFD, 8'h10, 8'hFE, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFD, 8'h10, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFD, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFD, 8'h10, 8'h01, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 8'h10, 8'h0F, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h10, 8'h10, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h10, 8'h01, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 8'h10, 8'h05, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 8'h10, 8'h04, 1'b0, 1'b0, 1'b0};

        // Reset, then en=0 with a toggling tick for 20 cycles
        preset_n = 1'b0;
        bus.psc_div = '0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        model_reset();
        repeat (3) cycle();
        check_model("reset");
        #2 preset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.tick = i[0];
            cycle();
            check("idle.cnt", 32'(bus.cnt), 32'h0);
            check("idle.last_cnt", 32'(bus.last_cnt), 32'h0);
            check("idle.pulses", 32'({bus.ovf, bus.udf, bus.cmp_match}), 32'h0);
        end

        // Directed vectors with constant expectations
        prev = 8'h00;
        for (int i = 0; i < 13; i++) begin
            set_in(tbl[i].load, tbl[i].en, tbl[i].updown, tbl[i].tick, tbl[i].ar, tbl[i].tdr, tbl[i].cmp);
            cycle();
            check($sformatf("vec%0d.cnt", i), 32'(bus.cnt), 32'(tbl[i].e_cnt));
            check($sformatf("vec%0d.last_cnt", i), 32'(bus.last_cnt), 32'(prev));
            check($sformatf("vec%0d.ovf", i), 32'(bus.ovf), 32'(tbl[i].e_ovf));
            check($sformatf("vec%0d.udf", i), 32'(bus.udf), 32'(tbl[i].e_udf));
            check($sformatf("vec%0d.cmp_match", i), 32'(bus.cmp_match), 32'(tbl[i].e_cmp));
            prev = tbl[i].e_cnt;
        end

        // Down auto-reload: from 04 the sequence is 03,02,01,00,05(udf) and repeats every 6 steps
        for (int k = 1; k <= 12; k++) begin
            set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 8'hF0);
            cycle();
            exp_v = 8'((4 - k % 6 + 6) % 6);
            if (exp_v == 8'h00 && (k % 6) == 4) exp_v = 8'h00;
            check("reload.cnt", 32'(bus.cnt), 32'((k % 6 == 5) ? 5 : (4 - (k % 6) + 6) % 6));
            check("reload.udf", 32'(bus.udf), 32'(k % 6 == 5));
        end

        // Prescaler psc_div=3: one step every 4th tick, then a load restarts the window
        bus.psc_div = 4'd3;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'hF0);
        cycle();
        for (int k = 1; k <= 6; k++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hF0);
            cycle();
            check("psc.cnt", 32'(bus.cnt), 32'(k / 4));
        end
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 8'hF0);
        cycle();
        check("psc.load_tick", 32'(bus.cnt), 32'h20);
        check("psc.load_nopulse", 32'({bus.ovf, bus.udf, bus.cmp_match}), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 8'hF0);
            cycle();
            check("psc.restart", 32'(bus.cnt), (k == 4) ? 32'h21 : 32'h20);
        end

        // psc_div lowered below the running prescale count: psc wraps mod 16 first
        bus.psc_div = 4'd5;
        repeat (4) cycle();
        bus.psc_div = 4'd1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            check_model("psc_shrink");
        end

        // Asynchronous reset mid-count
        #2 preset_n = 1'b0;
        model_reset();
        #1;
        check_model("async_rst");
        #2 preset_n = 1'b1;
        bus.psc_div = '0;

        // Randomized run against the reference model
        for (int n = 0; n < 2000; n++) begin
            bus.load        = ($urandom_range(0, 99) < 4);
            bus.en          = ($urandom_range(0, 99) < 92);
            bus.tick        = ($urandom_range(0, 99) < 75);
            if ($urandom_range(0, 99) < 5) bus.updown = $urandom_range(0, 1);
            if ($urandom_range(0, 99) < 5) bus.auto_reload = $urandom_range(0, 1);
            if ($urandom_range(0, 99) < 3) bus.psc_div = PSC_W'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 10) bus.tdr = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255))
                                                                                : 8'($urandom_range(250, 255));
            if ($urandom_range(0, 99) < 2) bus.cmp = 8'($urandom_range(0, 255));
            cycle();
            check_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
